// File: rtl/nios2_rdctrl_seq.sv
// Avalon-MM programmable read sequencer for the audio sample FIFO.
// Issues one FIFO read per sample tick, captures the sample, counts down and interrupts on completion.
module nios2_rdctrl_seq #(
    parameter int DW = 16,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [2:0]    address,
    input  logic          chipselect,
    input  logic          write_n,
    input  logic [31:0]   writedata,
    output logic [31:0]   readdata,
    output logic          irq,
    input  logic          sample_tick,
    input  logic          fifo_empty,
    output logic          fifo_rd,
    input  logic [DW-1:0] fifo_rdata
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_READ    = 2'd2;
    localparam logic [1:0] S_CAPTURE = 2'd3;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          r_run;
    logic          r_cont;
    logic          r_irq_en;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_remaining;
    logic          r_done;
    logic          r_underrun;
    logic [DW-1:0] r_last;
    logic [15:0]   r_urcnt;
    logic          r_fifo_rd;
    logic          r_irq;

    logic w_wr;
    logic w_wr_ctrl;
    logic w_wr_count;
    logic w_wr_stat;
    logic w_abort;
    logic w_busy;
    logic w_start;
    logic w_last_smp;
    logic w_done_set;
    logic w_ur_set;

    assign w_wr       = chipselect & ~write_n;
    assign w_wr_ctrl  = w_wr & (address == 3'd0);
    assign w_wr_count = w_wr & (address == 3'd1);
    assign w_wr_stat  = w_wr & (address == 3'd2);
    assign w_abort    = w_wr_ctrl & ~writedata[0];
    assign w_busy     = (r_state != S_IDLE);
    assign w_start    = (r_state == S_IDLE) & w_wr_ctrl & writedata[0] & (r_count != '0);
    assign w_last_smp = (r_remaining == CW'(1));

    // An abort seen during READ has already cleared r_run, so CAPTURE exits on either.
    assign w_done_set = ((r_state == S_IDLE) & w_wr_ctrl & writedata[0] & (r_count == '0)) |
                        ((r_state == S_CAPTURE) & w_last_smp & ~r_cont & r_run & ~w_abort);
    assign w_ur_set   = (r_state == S_WAIT) & ~w_abort & sample_tick & fifo_empty;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_start) w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (w_abort)
                    w_state_nxt = S_IDLE;
                else if (sample_tick & ~fifo_empty)
                    w_state_nxt = S_READ;
            end
            S_READ:    w_state_nxt = S_CAPTURE;
            S_CAPTURE: begin
                if (w_abort | ~r_run | (w_last_smp & ~r_cont))
                    w_state_nxt = S_IDLE;
                else
                    w_state_nxt = S_WAIT;
            end
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_fifo_rd <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_fifo_rd <= (w_state_nxt == S_READ);
            r_irq     <= r_irq_en & (r_done | r_underrun);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run    <= 1'b0;
            r_cont   <= 1'b0;
            r_irq_en <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_cont   <= writedata[1];
                r_irq_en <= writedata[2];
            end
            // While busy a run=1 write never restarts; it can only keep or drop run.
            if ((r_state == S_CAPTURE) && (w_state_nxt == S_IDLE))
                r_run <= 1'b0;
            else if (w_wr_ctrl)
                r_run <= (r_state == S_IDLE) ? w_start : (r_run & writedata[0]);
            if (w_wr_count)
                r_count <= writedata[CW-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_remaining <= '0;
            r_last      <= '0;
            r_urcnt     <= '0;
            r_done      <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            if (w_start)
                r_remaining <= r_count;
            else if (r_state == S_CAPTURE)
                r_remaining <= (w_last_smp && (w_state_nxt == S_WAIT)) ? r_count
                                                                         : r_remaining - CW'(1);
            if (r_state == S_CAPTURE)
                r_last <= fifo_rdata;
            if (w_start)
                r_urcnt <= '0;
            else if (w_ur_set && (r_urcnt != 16'hFFFF))
                r_urcnt <= r_urcnt + 16'd1;
            // Hardware set beats a same-cycle write-1-to-clear.
            r_done     <= w_done_set | (r_done & ~(w_wr_stat & writedata[1]));
            r_underrun <= w_ur_set | (r_underrun & ~(w_wr_stat & writedata[2]));
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            3'd0: readdata[2:0] = {r_irq_en, r_cont, r_run};
            3'd1: readdata[CW-1:0] = r_count;
            3'd2: begin
                readdata[2:0]       = {r_underrun, r_done, w_busy};
                readdata[16+CW-1:16] = r_remaining;
            end
            3'd3: readdata[DW-1:0] = r_last;
            3'd4: readdata[15:0] = r_urcnt;
            default: ;
        endcase
    end

    assign fifo_rd = r_fifo_rd;
    assign irq     = r_irq;

endmodule

// File: tb/tb_nios2_rdctrl_seq.sv
// Randomized bench for nios2_rdctrl_seq against a transaction-level model of the sequencer.
module tb_nios2_rdctrl_seq;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic        sample_tick;
    logic        fifo_empty;
    logic        fifo_rd;
    logic [15:0] fifo_rdata;

    nios2_rdctrl_seq #(.DW(16), .CW(16)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
        .sample_tick(sample_tick), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
        .fifo_rdata(fifo_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: m_age is how far the sample in flight has progressed since its tick was accepted
    // (0 = waiting for a tick, 1 = read cycle, 2 = capture cycle).
    bit m_busy, m_run, m_cont, m_ien, m_done, m_ur, m_irq, m_fifo_rd;
    int m_age, m_count, m_rem, m_urc, m_last;

    task automatic model_reset();
        m_busy = 0; m_run = 0; m_cont = 0; m_ien = 0; m_done = 0; m_ur = 0;
        m_irq = 0; m_fifo_rd = 0; m_age = 0; m_count = 0; m_rem = 0; m_urc = 0; m_last = 0;
    endtask

    task automatic model_step();
        bit wr, wc, ws, abort, stop, dset, uset;
        wr    = chipselect && !write_n;
        wc    = wr && address == 3'd0;
        ws    = wr && address == 3'd2;
        abort = wc && !writedata[0];
        dset  = 0;
        uset  = 0;
        m_irq = m_ien && (m_done || m_ur);
        if (!m_busy) begin
            if (wc) begin
                if (writedata[0] && m_count != 0) begin
                    m_busy = 1; m_age = 0; m_rem = m_count; m_urc = 0; m_run = 1;
                end else begin
                    if (writedata[0]) dset = 1;
                    m_run = 0;
                end
            end
        end else if (m_age == 0) begin
            if (abort) begin
                m_busy = 0; m_run = 0;
            end else if (sample_tick) begin
                if (fifo_empty) begin
                    uset = 1;
                    if (m_urc < 65535) m_urc++;
                end else m_age = 1;
            end
        end else if (m_age == 1) begin
            if (wc) m_run = m_run && writedata[0];
            m_age = 2;
        end else begin
            m_last = int'(fifo_rdata);
            stop = abort || !m_run;
            if (stop || (m_rem == 1 && !m_cont)) begin
                m_busy = 0; m_run = 0;
                if (!stop) dset = 1;
                m_rem = (m_rem - 1) & 16'hFFFF;
            end else begin
                m_rem = (m_rem == 1) ? m_count : m_rem - 1;
                if (wc) m_run = m_run && writedata[0];
            end
            m_age = 0;
        end
        if (wc) begin
            m_cont = writedata[1];
            m_ien  = writedata[2];
        end
        if (wr && address == 3'd1) m_count = int'(writedata[15:0]);
        m_done    = dset || (m_done && !(ws && writedata[1]));
        m_ur      = uset || (m_ur && !(ws && writedata[2]));
        m_fifo_rd = m_busy && m_age == 1;
    endtask

    function automatic logic [31:0] model_rdata(input logic [2:0] a);
        case (a)
            3'd0: return {29'd0, m_ien, m_cont, m_run};
            3'd1: return 32'(m_count);
            3'd2: return (32'(m_rem) << 16) | {29'd0, m_ur, m_done, m_busy};
            3'd3: return 32'(m_last);
            3'd4: return 32'(m_urc);
            default: return 32'd0;
        endcase
    endfunction

    int  tick_cnt = 4;
    int  cyc;
    bit  did_rst = 0;

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    endtask

    task automatic drive_inputs();
        int r;
        chipselect = 1'b0; write_n = 1'b1; writedata = $urandom;
        address    = 3'($urandom_range(0, 7));
        fifo_rdata = 16'($urandom);
        fifo_empty = (cyc >= 600) && ($urandom_range(0, 3) == 0);
        if (tick_cnt == 0) begin
            sample_tick = 1'b1;
            tick_cnt    = $urandom_range(2, 11);
        end else begin
            sample_tick = 1'b0;
            tick_cnt--;
        end
        r = $urandom_range(0, 99);
        if (!m_busy) begin
            if (r < 15)
                bus_write(3'd1, 32'($urandom_range(0, 4)));
            else if (r < 30)
                bus_write(3'd0, {29'd0, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1'b1});
            else if (r < 40)
                bus_write(3'd2, 32'($urandom_range(0, 7)));
            else if (r < 43)
                bus_write(3'($urandom_range(3, 7)), $urandom);
        end else begin
            if (r < 2 && cyc >= 800)
                bus_write(3'd0, {29'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0});
            else if (r < 5)
                bus_write(3'd2, 32'($urandom_range(0, 7)));
            else if (r < 7)
                bus_write(3'd1, 32'($urandom_range(1, 4)));
            else if (r < 9)
                bus_write(3'd0, {29'd0, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1'b1});
        end
    endtask

    initial begin
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; writedata = '0; address = '0;
        sample_tick = 1'b0; fifo_empty = 1'b0; fifo_rdata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        for (int a = 0; a < 8; a++) begin
            address = 3'(a);
            #1 chk("rst_rdata", readdata, 32'd0);
        end
        reset_n = 1'b1;
        for (cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            chk("fifo_rd", 32'(fifo_rd), 32'(m_fifo_rd));
            chk("irq", 32'(irq), 32'(m_irq));
            if (!did_rst && cyc >= 2500 && m_fifo_rd) begin
                did_rst = 1;
                reset_n = 1'b0;
                model_reset();
                #1 chk("midrst_fifo_rd", 32'(fifo_rd), 32'd0);
                chk("midrst_irq", 32'(irq), 32'd0);
                for (int a = 0; a < 5; a++) begin
                    address = 3'(a);
                    #1 chk("midrst_rdata", readdata, 32'd0);
                end
                @(negedge clk);
                reset_n = 1'b1;
            end
            drive_inputs();
            #1 chk("rdata", readdata, model_rdata(address));
        end
        if (!did_rst) chk("midrst_taken", 32'd0, 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
